// File: rtl/spi_master_byte.sv
// spi_master_byte
// Byte-stream SPI master, mode 0 (SCLK idles low, data sampled on the rising
// edge, changed on the falling edge), MSB first. Bytes arrive on a
// valid/ready stream; each byte is shifted out on MOSI while MISO is captured,
// and the received byte is returned with a one-cycle rx_valid strobe. NSS
// stays low across consecutive bytes until a byte flagged last completes.
//
// Parameters:
//   CLK_DIV  SCLK half-period in clk cycles (1..255)
//   CS_IDLE  minimum NSS-high gap between frames, in half-periods (1..15)
//
// Ports:
//   clk, reset_n          clock (rising edge), async active-low reset
//   tx_data/tx_last       byte to send and end-of-frame flag
//   tx_valid/tx_ready     transmit handshake
//   rx_data/rx_valid      received byte and its one-cycle strobe
//   busy                  high whenever the FSM is not idle
//   spi_nss/sclk/mosi     SPI outputs (NSS active low, SCLK idles low)
//   spi_miso              SPI input (2-flop synchronised internally)

module spi_master_byte #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_IDLE = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       spi_nss,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [3:0] GAP_LAST = 4'(CS_IDLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_NEXT,
    ST_HOLD,
    ST_GAP
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [3:0] bit_q, bit_d;      // half-period count in SHIFT, gap count in GAP
  logic [6:0] tx_sh_q, tx_sh_d;  // remaining bits; bit 7 goes straight to MOSI
  logic [7:0] rx_sh_q, rx_sh_d;
  logic       last_q, last_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       nss_q, nss_d;
  logic       sclk_q, sclk_d;
  logic       mosi_q, mosi_d;

  logic       rst_meta_q, rst_sync_q;
  logic       miso_s1_q, miso_s2_q;
  logic       running;
  logic       tick;

  // Reset asserts asynchronously and releases synchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      miso_s1_q <= 1'b0;
      miso_s2_q <= 1'b0;
    end else begin
      miso_s1_q <= spi_miso;
      miso_s2_q <= miso_s1_q;
    end
  end

  // Divider runs only while waiting on half-periods; every transition out of a
  // running state happens on a tick, so entering any state starts it at 0.
  assign running = (state_q == ST_SETUP) || (state_q == ST_SHIFT) ||
                   (state_q == ST_HOLD)  || (state_q == ST_GAP);
  assign tick    = running && (div_q == DIV_LAST);

  always_comb begin
    state_d    = state_q;
    div_d      = '0;
    bit_d      = bit_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    last_d     = last_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    nss_d      = nss_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;

    if (running && !tick) begin
      div_d = div_q + 8'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          tx_sh_d = tx_data[6:0];
          last_d  = tx_last;
          mosi_d  = tx_data[7];
          nss_d   = 1'b0;
          bit_d   = '0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          bit_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          bit_d = bit_q + 4'd1;
          if (!bit_q[0]) begin
            sclk_d  = 1'b1;
            rx_sh_d = {rx_sh_q[6:0], miso_s2_q};
          end else begin
            sclk_d  = 1'b0;
            mosi_d  = tx_sh_q[6];
            tx_sh_d = {tx_sh_q[5:0], 1'b0};
            if (bit_q == 4'd15) begin
              rx_data_d  = rx_sh_q;
              rx_valid_d = 1'b1;
              bit_d      = '0;
              state_d    = last_q ? ST_HOLD : ST_NEXT;
            end
          end
        end
      end
      ST_NEXT: begin
        if (tx_valid) begin
          tx_sh_d = tx_data[6:0];
          last_d  = tx_last;
          mosi_d  = tx_data[7];
          bit_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_HOLD: begin
        if (tick) begin
          nss_d   = 1'b1;
          bit_d   = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tick) begin
          if (bit_q == GAP_LAST) begin
            bit_d   = '0;
            state_d = ST_IDLE;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      last_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      nss_q      <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      last_q     <= last_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      nss_q      <= nss_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
    end
  end

  assign tx_ready = (state_q == ST_IDLE) || (state_q == ST_NEXT);
  assign busy     = (state_q != ST_IDLE);
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign spi_nss  = nss_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_master_byte.sv
// Bench for spi_master_byte: u_dut at CLK_DIV=2 with a mode-0 slave model,
// u_dut1 at CLK_DIV=1 with MOSI looped straight back to MISO.

module tb_spi_master_byte;

  logic       clk = 1'b0;
  logic       reset_n;

  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       spi_nss;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_miso = 1'b0;

  logic [7:0] tx_data1;
  logic       tx_last1;
  logic       tx_valid1;
  logic       tx_ready1;
  logic [7:0] rx_data1;
  logic       rx_valid1;
  logic       busy1;
  logic       spi_nss1;
  logic       spi_sclk1;
  logic       spi_mosi1;
  logic       spi_miso1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  spi_master_byte #(.CLK_DIV(2), .CS_IDLE(2)) u_dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .tx_data  (tx_data),
    .tx_last  (tx_last),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .spi_nss  (spi_nss),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  spi_master_byte #(.CLK_DIV(1), .CS_IDLE(2)) u_dut1 (
    .clk      (clk),
    .reset_n  (reset_n),
    .tx_data  (tx_data1),
    .tx_last  (tx_last1),
    .tx_valid (tx_valid1),
    .tx_ready (tx_ready1),
    .rx_data  (rx_data1),
    .rx_valid (rx_valid1),
    .busy     (busy1),
    .spi_nss  (spi_nss1),
    .spi_sclk (spi_sclk1),
    .spi_mosi (spi_mosi1),
    .spi_miso (spi_miso1)
  );

  assign spi_miso1 = spi_mosi1;

  // ---------------- monitors ----------------
  int          cyc = 0;
  int          rise_cnt = 0, rise1_cnt = 0;
  logic [31:0] mosi_bits = '0, mosi1_bits = '0;
  int          rise1_t [64];
  int          rxv_cnt = 0, rxv1_cnt = 0;
  logic [7:0]  rx_log [16];
  logic [7:0]  rx1_log [16];
  int          nss_low_cnt = 0, nss1_low_cnt = 0;
  int          nss_rise_cnt = 0;
  int          nss_rise_cyc = 0, tready_rise_cyc = 0;

  always @(posedge clk) cyc++;

  always @(posedge spi_sclk) begin
    rise_cnt++;
    mosi_bits = {mosi_bits[30:0], spi_mosi};
  end

  always @(posedge spi_sclk1) begin
    rise1_t[rise1_cnt % 64] = cyc;
    rise1_cnt++;
    mosi1_bits = {mosi1_bits[30:0], spi_mosi1};
  end

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      rx_log[rxv_cnt % 16] = rx_data;
      rxv_cnt++;
    end
    if (rx_valid1 === 1'b1) begin
      rx1_log[rxv1_cnt % 16] = rx_data1;
      rxv1_cnt++;
    end
    if (spi_nss === 1'b0) nss_low_cnt++;
    if (spi_nss1 === 1'b0) nss1_low_cnt++;
  end

  always @(posedge spi_nss) begin
    nss_rise_cnt++;
    nss_rise_cyc = cyc;
  end

  always @(posedge tx_ready) tready_rise_cyc = cyc;

  // Mode-0 slave for u_dut: first bit presented at NSS fall, next bit right
  // after each rising edge; a fresh byte is loaded every 8 rises.
  logic [7:0] slave_bytes [4];
  logic [7:0] sl_sh = '0;
  int         sl_bit = 0, sl_idx = 0;

  always @(negedge spi_nss or posedge spi_sclk) begin
    if (spi_sclk !== 1'b1) begin
      sl_idx = 0;
      sl_bit = 0;
      sl_sh  = slave_bytes[0];
    end else begin
      sl_bit++;
      if (sl_bit == 8) begin
        sl_bit = 0;
        sl_idx++;
        sl_sh  = slave_bytes[sl_idx % 4];
      end else begin
        sl_sh = {sl_sh[6:0], 1'b0};
      end
    end
    spi_miso = sl_sh[7];
  end

  // ---------------- drivers ----------------
  task automatic send(input int sel, input logic [7:0] d, input logic last);
    int n = 0;
    @(negedge clk);
    if (sel == 0) begin
      tx_data = d; tx_last = last; tx_valid = 1'b1;
    end else begin
      tx_data1 = d; tx_last1 = last; tx_valid1 = 1'b1;
    end
    while (((sel == 0) ? tx_ready : tx_ready1) !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (n >= 2000) $display("FAIL handshake_timeout: dut%0d byte %02h not accepted within %0d cycles", sel, d, n);
    else pass_cnt++;
    @(posedge clk);
  endtask

  task automatic drop(input int sel);
    @(negedge clk);
    if (sel == 0) tx_valid = 1'b0;
    else tx_valid1 = 1'b0;
  endtask

  task automatic wait_idle(input int sel, input int budget);
    int n = 0;
    @(negedge clk);
    while (((sel == 0) ? busy : busy1) !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (n >= budget) $display("FAIL idle_timeout: dut%0d still busy after %0d cycles", sel, n);
    else pass_cnt++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({spi_nss, spi_sclk, spi_mosi, rx_valid, tx_ready, busy} !== 6'b100010)
      $display("FAIL reset_outputs: got nss/sclk/mosi/rxv/rdy/busy=%b required 100010",
               {spi_nss, spi_sclk, spi_mosi, rx_valid, tx_ready, busy});
    else pass_cnt++;
    total_cnt++;
    if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %02h required 00", rx_data);
    else pass_cnt++;
    total_cnt++;
    if ({spi_nss1, spi_sclk1, spi_mosi1, rx_valid1, tx_ready1, busy1} !== 6'b100010)
      $display("FAIL reset_outputs_div1: got %b required 100010",
               {spi_nss1, spi_sclk1, spi_mosi1, rx_valid1, tx_ready1, busy1});
    else pass_cnt++;
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    total_cnt++;
    if ({spi_nss, spi_sclk, tx_ready, busy} !== 4'b1010)
      $display("FAIL post_reset_idle: got nss/sclk/rdy/busy=%b required 1010",
               {spi_nss, spi_sclk, tx_ready, busy});
    else pass_cnt++;
  endtask

  task automatic test_single_byte();
    int b_rise = rise_cnt, b_rxv = rxv_cnt, b_nss = nss_low_cnt;
    logic [31:0] mb;
    slave_bytes[0] = 8'h3C;
    send(0, 8'hA5, 1'b1);
    drop(0);
    wait_idle(0, 500);
    mb = mosi_bits;
    total_cnt++;
    if (mb[7:0] !== 8'hA5) $display("FAIL single_mosi: got %02h required a5", mb[7:0]);
    else pass_cnt++;
    total_cnt++;
    if (rise_cnt - b_rise !== 8) $display("FAIL single_rises: got %0d required 8", rise_cnt - b_rise);
    else pass_cnt++;
    total_cnt++;
    if (rxv_cnt - b_rxv !== 1) $display("FAIL single_rxv: got %0d pulses required 1", rxv_cnt - b_rxv);
    else pass_cnt++;
    total_cnt++;
    if (rx_log[b_rxv % 16] !== 8'h3C) $display("FAIL single_rx: got %02h required 3c", rx_log[b_rxv % 16]);
    else pass_cnt++;
    total_cnt++;
    if (rx_data !== 8'h3C) $display("FAIL single_rx_hold: got %02h required 3c", rx_data);
    else pass_cnt++;
    total_cnt++;
    if (nss_low_cnt - b_nss !== 36) $display("FAIL single_nss_low: got %0d clk required 36", nss_low_cnt - b_nss);
    else pass_cnt++;
  endtask

  task automatic test_multi_byte();
    int b_rise = rise_cnt, b_rxv = rxv_cnt, b_nss = nss_low_cnt, b_nr = nss_rise_cnt;
    logic [31:0] mb;
    slave_bytes[0] = 8'hC1;
    slave_bytes[1] = 8'h5E;
    slave_bytes[2] = 8'h33;
    send(0, 8'h80, 1'b0);
    send(0, 8'h4A, 1'b0);
    send(0, 8'h7B, 1'b1);
    drop(0);
    wait_idle(0, 1000);
    mb = mosi_bits;
    total_cnt++;
    if (mb[23:0] !== 24'h804A7B) $display("FAIL multi_mosi: got %06h required 804a7b", mb[23:0]);
    else pass_cnt++;
    total_cnt++;
    if (rise_cnt - b_rise !== 24) $display("FAIL multi_rises: got %0d required 24", rise_cnt - b_rise);
    else pass_cnt++;
    total_cnt++;
    if (rxv_cnt - b_rxv !== 3) $display("FAIL multi_rxv: got %0d pulses required 3", rxv_cnt - b_rxv);
    else pass_cnt++;
    total_cnt++;
    if ({rx_log[b_rxv % 16], rx_log[(b_rxv + 1) % 16], rx_log[(b_rxv + 2) % 16]} !== 24'hC15E33)
      $display("FAIL multi_rx: got %02h %02h %02h required c1 5e 33",
               rx_log[b_rxv % 16], rx_log[(b_rxv + 1) % 16], rx_log[(b_rxv + 2) % 16]);
    else pass_cnt++;
    total_cnt++;
    if (nss_rise_cnt - b_nr !== 1) $display("FAIL multi_nss_cont: got %0d nss rises required 1", nss_rise_cnt - b_nr);
    else pass_cnt++;
    total_cnt++;
    if (nss_low_cnt - b_nss !== 102) $display("FAIL multi_nss_low: got %0d clk required 102", nss_low_cnt - b_nss);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    int b_rise = rise_cnt, b_rxv = rxv_cnt, b_nr = nss_rise_cnt;
    int viol = 0, n = 0, stall_rise;
    logic [31:0] mb;
    slave_bytes[0] = 8'h9D;
    slave_bytes[1] = 8'h42;
    send(0, 8'h11, 1'b0);
    drop(0);
    while (tx_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (n >= 500) $display("FAIL stall_next_timeout: tx_ready not seen within %0d cycles", n);
    else pass_cnt++;
    stall_rise = rise_cnt;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (spi_nss !== 1'b0 || spi_sclk !== 1'b0 || busy !== 1'b1) viol++;
    end
    total_cnt++;
    if (viol !== 0) $display("FAIL stall_lines: got %0d bad cycles required 0", viol);
    else pass_cnt++;
    total_cnt++;
    if (rise_cnt !== stall_rise) $display("FAIL stall_sclk: got %0d rises during stall required 0", rise_cnt - stall_rise);
    else pass_cnt++;
    send(0, 8'h22, 1'b1);
    drop(0);
    wait_idle(0, 500);
    mb = mosi_bits;
    total_cnt++;
    if (mb[15:0] !== 16'h1122) $display("FAIL stall_mosi: got %04h required 1122", mb[15:0]);
    else pass_cnt++;
    total_cnt++;
    if (rise_cnt - b_rise !== 16) $display("FAIL stall_rises: got %0d required 16", rise_cnt - b_rise);
    else pass_cnt++;
    total_cnt++;
    if ({rx_log[b_rxv % 16], rx_log[(b_rxv + 1) % 16]} !== 16'h9D42 || rxv_cnt - b_rxv !== 2)
      $display("FAIL stall_rx: got %0d pulses %02h %02h required 2 pulses 9d 42",
               rxv_cnt - b_rxv, rx_log[b_rxv % 16], rx_log[(b_rxv + 1) % 16]);
    else pass_cnt++;
    total_cnt++;
    if (nss_rise_cnt - b_nr !== 1) $display("FAIL stall_nss_cont: got %0d nss rises required 1", nss_rise_cnt - b_nr);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int b_rise = rise_cnt, b_rxv = rxv_cnt, b_nss = nss_low_cnt;
    logic [31:0] mb;
    slave_bytes[0] = 8'hE7;
    send(0, 8'h5A, 1'b1);
    send(0, 8'hC3, 1'b1);   // tx_data changes while frame 1 is in SETUP
    total_cnt++;
    if (tready_rise_cyc - nss_rise_cyc !== 4)
      $display("FAIL b2b_gap: got %0d clk NSS-high before tx_ready required 4", tready_rise_cyc - nss_rise_cyc);
    else pass_cnt++;
    drop(0);
    wait_idle(0, 500);
    mb = mosi_bits;
    total_cnt++;
    if (mb[15:0] !== 16'h5AC3) $display("FAIL b2b_mosi: got %04h required 5ac3", mb[15:0]);
    else pass_cnt++;
    total_cnt++;
    if (rise_cnt - b_rise !== 16) $display("FAIL b2b_rises: got %0d required 16", rise_cnt - b_rise);
    else pass_cnt++;
    total_cnt++;
    if ({rx_log[b_rxv % 16], rx_log[(b_rxv + 1) % 16]} !== 16'hE7E7 || rxv_cnt - b_rxv !== 2)
      $display("FAIL b2b_rx: got %0d pulses %02h %02h required 2 pulses e7 e7",
               rxv_cnt - b_rxv, rx_log[b_rxv % 16], rx_log[(b_rxv + 1) % 16]);
    else pass_cnt++;
    total_cnt++;
    if (nss_low_cnt - b_nss !== 72) $display("FAIL b2b_nss_low: got %0d clk required 72", nss_low_cnt - b_nss);
    else pass_cnt++;
  endtask

  task automatic test_reset_midframe();
    int b_rise = rise_cnt, b_rxv = rxv_cnt, n = 0;
    logic [31:0] mb;
    slave_bytes[0] = 8'h0F;
    send(0, 8'hF0, 1'b1);
    drop(0);
    while (rise_cnt - b_rise < 4 && n < 500) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (n >= 500) $display("FAIL midreset_wait: 4th rise not seen within %0d cycles", n);
    else pass_cnt++;
    #1 reset_n = 1'b0;
    #1;
    total_cnt++;
    if ({spi_nss, spi_sclk, busy, tx_ready, rx_valid} !== 5'b10010)
      $display("FAIL midreset_async: got nss/sclk/busy/rdy/rxv=%b required 10010",
               {spi_nss, spi_sclk, busy, tx_ready, rx_valid});
    else pass_cnt++;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    total_cnt++;
    if (rxv_cnt !== b_rxv || rx_data !== 8'h00)
      $display("FAIL midreset_no_rx: got %0d pulses rx_data %02h required 0 pulses 00", rxv_cnt - b_rxv, rx_data);
    else pass_cnt++;
    slave_bytes[0] = 8'h69;
    b_rise = rise_cnt;
    send(0, 8'h96, 1'b1);
    drop(0);
    wait_idle(0, 500);
    mb = mosi_bits;
    total_cnt++;
    if (mb[7:0] !== 8'h96 || rise_cnt - b_rise !== 8)
      $display("FAIL midreset_next_mosi: got %02h in %0d rises required 96 in 8", mb[7:0], rise_cnt - b_rise);
    else pass_cnt++;
    total_cnt++;
    if (rxv_cnt - b_rxv !== 1 || rx_data !== 8'h69)
      $display("FAIL midreset_next_rx: got %0d pulses %02h required 1 pulse 69", rxv_cnt - b_rxv, rx_data);
    else pass_cnt++;
  endtask

  // CLK_DIV=1 with direct loopback: the 2-flop MISO synchroniser delays the
  // looped data by one bit, so the captured byte is the sent byte shifted
  // right by one with the idle MOSI level (0) entering at the top.
  task automatic test_div1_loopback();
    logic [7:0] vec [3];
    logic [7:0] exp_rx;
    logic [31:0] mb;
    int b_rise, b_rxv, b_nss;
    vec[0] = 8'h00;
    vec[1] = 8'hFF;
    vec[2] = 8'h55;
    for (int i = 0; i < 3; i++) begin
      b_rise = rise1_cnt;
      b_rxv  = rxv1_cnt;
      b_nss  = nss1_low_cnt;
      exp_rx = vec[i] >> 1;
      send(1, vec[i], 1'b1);
      drop(1);
      wait_idle(1, 200);
      mb = mosi1_bits;
      total_cnt++;
      if (mb[7:0] !== vec[i] || rise1_cnt - b_rise !== 8)
        $display("FAIL div1_mosi: got %02h in %0d rises required %02h in 8", mb[7:0], rise1_cnt - b_rise, vec[i]);
      else pass_cnt++;
      total_cnt++;
      if (rise1_t[(b_rise + 7) % 64] - rise1_t[b_rise % 64] !== 14)
        $display("FAIL div1_period: got %0d clk first-to-8th rise required 14",
                 rise1_t[(b_rise + 7) % 64] - rise1_t[b_rise % 64]);
      else pass_cnt++;
      total_cnt++;
      if (rxv1_cnt - b_rxv !== 1 || rx1_log[b_rxv % 16] !== exp_rx)
        $display("FAIL div1_rx: got %0d pulses %02h required 1 pulse %02h", rxv1_cnt - b_rxv, rx1_log[b_rxv % 16], exp_rx);
      else pass_cnt++;
      total_cnt++;
      if (nss1_low_cnt - b_nss !== 18) $display("FAIL div1_nss_low: got %0d clk required 18", nss1_low_cnt - b_nss);
      else pass_cnt++;
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    tx_data   = '0;
    tx_last   = 1'b0;
    tx_valid  = 1'b0;
    tx_data1  = '0;
    tx_last1  = 1'b0;
    tx_valid1 = 1'b0;
    for (int i = 0; i < 4; i++) slave_bytes[i] = '0;
    test_reset();
    test_single_byte();
    test_multi_byte();
    test_stall();
    test_back_to_back();
    test_reset_midframe();
    test_div1_loopback();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded 500000 time units, %0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1, "watchdog expired");
  end

endmodule
